// File: rtl/seq_exec_alu.sv
// Execution-stage ALU with valid/ready handshakes on operands and result.
// Shifts run 1 bit per cycle unless SEQ_ALU_FAST_SHIFT_EN selects a barrel shifter.
module seq_exec_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
`ifndef SEQ_ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] step;
`endif

  function automatic logic [WIDTH-1:0] alu_comb(input logic [3:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (sel)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {{(WIDTH-1){1'b0}}, sa < sb};
      ALU_SLTU: r = {{(WIDTH-1){1'b0}}, a < b};
`ifdef SEQ_ALU_FAST_SHIFT_EN
      ALU_SLL:  r = a << b[SHAMT_W-1:0];
      ALU_SRL:  r = a >> b[SHAMT_W-1:0];
      ALU_SRA:  r = sa >>> b[SHAMT_W-1:0];
`endif
      default:  r = '0;
    endcase
    return r;
  endfunction

`ifndef SEQ_ALU_FAST_SHIFT_EN
  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] sel,
                                                  input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (sel)
      ALU_SLL: r = {v[WIDTH-2:0], 1'b0};
      ALU_SRL: r = {1'b0, v[WIDTH-1:1]};
      ALU_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign step = shift_step(op_q, acc_q);
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef SEQ_ALU_FAST_SHIFT_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
`ifndef SEQ_ALU_FAST_SHIFT_EN
          if (ALU_sel == ALU_SLL || ALU_sel == ALU_SRL || ALU_sel == ALU_SRA) begin
            // A zero shift amount retires immediately with the operand unchanged.
            if (op_b[SHAMT_W-1:0] == '0) begin
              result_d = op_a;
              zero_d   = (op_a == '0);
            end else begin
              acc_d   = op_a;
              cnt_d   = op_b[SHAMT_W-1:0];
              op_d    = ALU_sel;
              state_d = SHIFT;
            end
          end else begin
            result_d = alu_comb(ALU_sel, op_a, op_b);
            zero_d   = (result_d == '0);
          end
`else
          result_d = alu_comb(ALU_sel, op_a, op_b);
          zero_d   = (result_d == '0);
`endif
        end
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      SHIFT: begin
        acc_d = step;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = step;
          zero_d   = (step == '0);
          state_d  = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_exec_alu.sv
// Directed bench for seq_exec_alu; define SEQ_ALU_FAST_SHIFT_EN to target the barrel-shift build.
module tb_seq_exec_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [3:0]  ALU_sel;
  logic [31:0] op_a, op_b, result;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_exec_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_sel(ALU_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    ALU_sel  = sel;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0000_0013;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALU_sel = 4'b0000; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b result=%h zero=%b busy=%b, want 1 0 00000000 1 0",
               in_ready, out_valid, result, zero, busy);
    end
    issue(4'b0000, 32'd3, 32'd4);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd7 || zero !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_before_reset: out_valid=%b result=%h zero=%b busy=%b in_ready=%b, want 1 00000007 0 1 0",
               out_valid, result, zero, busy, in_ready);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b result=%h zero=%b in_ready=%b busy=%b, want 0 00000000 1 1 0",
               out_valid, result, zero, in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(4'b0000, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: out_valid=%b result=%h zero=%b, want 1 00000000 1", out_valid, result, zero);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
      errors++;
      $display("FAIL add_retire: out_valid=%b in_ready=%b result=%h, want 0 1 00000000", out_valid, in_ready, result);
    end
    issue(4'b0001, 32'd5, 32'd7);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: out_valid=%b result=%h zero=%b, want 1 fffffffe 0", out_valid, result, zero);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_logic_compare();
    logic [3:0]  sel_t [9] = '{4'b1101, 4'b1111, 4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0111, 4'b0011, 4'b0001};
    logic [31:0] a_t   [9] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001,
                               32'hF0F0_0000, 32'hFF00_FF00, 32'hAAAA_5555, 32'h0000_0005, 32'h8000_0000};
    logic [31:0] b_t   [9] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                               32'h0000_0F0F, 32'h0FF0_0FF0, 32'hFFFF_0000, 32'h0000_0006, 32'h0000_0001};
    logic [31:0] e_t   [9] = '{32'd1, 32'd0, 32'd0, 32'd1,
                               32'hF0F0_0F0F, 32'h0F00_0F00, 32'h5555_5555, 32'd0, 32'h7FFF_FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(sel_t[i], a_t[i], b_t[i]);
      checks++;
      if (out_valid !== 1'b1 || result !== e_t[i] || zero !== (e_t[i] == 32'd0)) begin
        errors++;
        $display("FAIL op_%0d_sel_%b: out_valid=%b result=%h zero=%b, want 1 %h %b",
                 i, sel_t[i], out_valid, result, zero, e_t[i], (e_t[i] == 32'd0));
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_shift();
    logic [3:0]  sel_t [5] = '{4'b1010, 4'b1000, 4'b1001, 4'b1010, 4'b1000};
    logic [31:0] a_t   [5] = '{32'h8000_0010, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b_t   [5] = '{32'd4, 32'd3, 32'd31, 32'h21, 32'd31};
    logic [31:0] e_t   [5] = '{32'hF800_0001, 32'h0000_0008, 32'h0000_0001, 32'h3FFF_FFFF, 32'h8000_0000};
    int          n_t   [5] = '{4, 3, 31, 1, 31};
    int lat, exp_lat;
    logic ready_seen;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = 1 + n_t[i];
`endif
      issue(sel_t[i], a_t[i], b_t[i]);
      lat = 1;
      ready_seen = 1'b0;
      while (!out_valid && lat < 100) begin
        if (in_ready) ready_seen = 1'b1;
        @(posedge clk); @(negedge clk);
        lat++;
      end
      checks++;
      if (out_valid !== 1'b1 || lat != exp_lat || result !== e_t[i] || ready_seen !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL shift_%0d_sel_%b: out_valid=%b latency=%0d result=%h ready_seen=%b, want 1 %0d %h 0",
                 i, sel_t[i], out_valid, lat, result, ready_seen, exp_lat, e_t[i]);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(4'b1000, 32'h1234_5678, 32'h0000_0020);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h1234_5678 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b result=%h in_ready=%b busy=%b, want 1 12345678 0 1",
                 i, out_valid, result, in_ready, busy);
      end
      ALU_sel = 4'b0000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h1234_5678 || zero !== 1'b0) begin
      errors++;
      $display("FAIL hold_end: out_valid=%b result=%h zero=%b, want 1 12345678 0", out_valid, result, zero);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h1234_5678) begin
      errors++;
      $display("FAIL hold_retire: out_valid=%b in_ready=%b result=%h, want 0 1 12345678", out_valid, in_ready, result);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic seen;
    out_ready = 1'b1;
    issue(4'b1000, 32'd1, 32'd31);
    repeat (8) @(negedge clk);
`ifndef SEQ_ALU_FAST_SHIFT_EN
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift_busy: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
`endif
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift_reset: busy=%b in_ready=%b out_valid=%b result=%h zero=%b, want 0 1 0 00000000 1",
               busy, in_ready, out_valid, result, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL aborted_shift: out_valid_seen=%b in_ready=%b, want 0 1", seen, in_ready);
    end
    issue(4'b0000, 32'd2, 32'd3);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd5 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_after_abort: out_valid=%b result=%h zero=%b, want 1 00000005 0", out_valid, result, zero);
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_compare();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
